uart_frame_tx: RTL and testbench

Hardware frame transmitter for the logic-analyzer kernel. It reads a run of 16-bit capture samples from sample memory and streams them as a framed byte sequence into the `uart_tx6` transmit FIFO, without involving the PicoBlaze. It drives the same `data_in` / `utx_buffer_write` / `utx_buffer_full` interface that `command_control_hub` drives today, and is muxed onto it while `busy` is high.

---
 rtl/la_pkg.sv | 31 +++
 rtl/uart_frame_tx_if.sv | 39 +++
 rtl/uart_frame_tx.sv | 177 +++++++++++++++++
 tb/tb_uart_frame_tx.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/la_pkg.sv
// ---------------------------------------------------------------------------
// la_pkg
// Shared definitions for the logic-analyzer kernel frame transmitter.
//   frame_state_e : states of the uart_frame_tx frame sequencer
//   SOF_DEFAULT   : default start-of-frame marker byte
//   frame_len()   : number of bytes in a frame carrying n samples (2n+4)
// ---------------------------------------------------------------------------
package la_pkg;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SOF,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_FETCH,
    ST_WAIT,
    ST_D_HI,
    ST_D_LO,
    ST_CSUM,
    ST_DONE
  } frame_state_e;

  // SOF + two count bytes + two bytes per sample + checksum.
  // 18 bits because 2*65535+4 does not fit in 17.
  function automatic logic [17:0] frame_len(input logic [15:0] n);
    return {1'b0, n, 1'b0} + 18'd4;
  endfunction

endpackage

// File: rtl/uart_frame_tx_if.sv
// ---------------------------------------------------------------------------
// uart_frame_tx_if
// Bus bundle between the frame transmitter, sample memory and the uart_tx6
// transmit FIFO.
//   mem_addr / mem_rd_en / mem_rd_data : synchronous sample-memory read port
//   data_in / utx_buffer_write         : byte and write strobe into the FIFO
//   utx_buffer_full                    : FIFO back-pressure
// master = the transmitter, slave = the memory/FIFO side.
// ---------------------------------------------------------------------------
interface uart_frame_tx_if #(
  parameter int unsigned ADDR_W = 10
);

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [15:0]       mem_rd_data;
  logic [7:0]        data_in;
  logic              utx_buffer_write;
  logic              utx_buffer_full;

  modport master (
    output mem_addr,
    output mem_rd_en,
    input  mem_rd_data,
    output data_in,
    output utx_buffer_write,
    input  utx_buffer_full
  );

  modport slave (
    input  mem_addr,
    input  mem_rd_en,
    output mem_rd_data,
    input  data_in,
    input  utx_buffer_write,
    output utx_buffer_full
  );

endinterface

// File: rtl/uart_frame_tx.sv
// ---------------------------------------------------------------------------
// uart_frame_tx
// Streams a run of 16-bit capture samples from sample memory into the
// uart_tx6 FIFO as a framed byte sequence:
//   SOF, N[15:8], N[7:0], {sample[15:8], sample[7:0]} x N, CSUM
// where CSUM is the XOR of every byte after SOF.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   start         : one-cycle frame request, honoured only in IDLE
//   abort         : drop the frame in progress without pulsing done
//   base_addr     : first sample address (captured on start)
//   num_samples   : sample count N (captured on start)
//   busy          : frame in progress (muxes this block onto the FIFO port)
//   done          : one-cycle pulse when a frame completes
//   bus           : memory read port and FIFO write port (master side)
// ---------------------------------------------------------------------------
module uart_frame_tx
  import la_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter logic [7:0]  SOF    = SOF_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       num_samples,
  output logic              busy,
  output logic              done,
  uart_frame_tx_if.master   bus
);

  frame_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       n_q, n_d;
  logic [15:0]       rem_q, rem_d;
  logic [7:0]        sample_lo_q, sample_lo_d;
  logic [7:0]        data_q, data_d;
  logic [7:0]        csum_q, csum_d;

  logic byte_state;
  logic wr_ok;
  logic start_ok;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers; reset clears everything so a mid-frame reset leaves
  // no stale address, byte or checksum behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= '0;
      n_q         <= '0;
      rem_q       <= '0;
      sample_lo_q <= '0;
      data_q      <= '0;
      csum_q      <= '0;
    end else begin
      addr_q      <= addr_d;
      n_q         <= n_d;
      rem_q       <= rem_d;
      sample_lo_q <= sample_lo_d;
      data_q      <= data_d;
      csum_q      <= csum_d;
    end
  end

  // Next-state logic. Byte states only move on an actual FIFO write, so a
  // full FIFO simply parks the sequencer. abort wins over everything,
  // including a start arriving in the same IDLE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_SOF;
      ST_SOF:    if (wr_ok) state_d = ST_CNT_HI;
      ST_CNT_HI: if (wr_ok) state_d = ST_CNT_LO;
      ST_CNT_LO: if (wr_ok) state_d = (rem_q == 16'd0) ? ST_CSUM : ST_FETCH;
      ST_FETCH:  state_d = ST_WAIT;
      ST_WAIT:   state_d = ST_D_HI;
      ST_D_HI:   if (wr_ok) state_d = ST_D_LO;
      ST_D_LO:   if (wr_ok) state_d = (rem_q == 16'd1) ? ST_CSUM : ST_FETCH;
      ST_CSUM:   if (wr_ok) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // Datapath updates. data_q always holds the byte to be written in the
  // next byte state, so it is loaded on the transition into that state and
  // stays put while the FIFO is full. The checksum folds in each byte as it
  // is written (SOF excluded); the final CSUM byte is formed from the
  // accumulator plus the byte being written in the same cycle.
  always_comb begin
    addr_d      = addr_q;
    n_d         = n_q;
    rem_d       = rem_q;
    sample_lo_d = sample_lo_q;
    data_d      = data_q;
    csum_d      = csum_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          addr_d = base_addr;
          n_d    = num_samples;
          rem_d  = num_samples;
          csum_d = 8'h00;
          data_d = SOF;
        end
      end
      ST_SOF: begin
        if (wr_ok) data_d = n_q[15:8];
      end
      ST_CNT_HI: begin
        if (wr_ok) begin
          csum_d = csum_q ^ data_q;
          data_d = n_q[7:0];
        end
      end
      ST_CNT_LO: begin
        if (wr_ok) begin
          csum_d = csum_q ^ data_q;
          if (rem_q == 16'd0) data_d = csum_q ^ data_q;
        end
      end
      ST_WAIT: begin
        data_d      = bus.mem_rd_data[15:8];
        sample_lo_d = bus.mem_rd_data[7:0];
      end
      ST_D_HI: begin
        if (wr_ok) begin
          csum_d = csum_q ^ data_q;
          data_d = sample_lo_q;
        end
      end
      ST_D_LO: begin
        if (wr_ok) begin
          csum_d = csum_q ^ data_q;
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 16'd1;
          if (rem_q == 16'd1) data_d = csum_q ^ data_q;
        end
      end
      ST_CSUM: begin
        if (wr_ok) csum_d = csum_q ^ data_q;
      end
      default: begin
      end
    endcase
  end

  // Outputs. The write strobe is combinational so a full flag stalls the
  // byte in the same cycle; abort also gates it so an aborted frame never
  // pushes another byte.
  always_comb begin
    byte_state = (state_q == ST_SOF)  || (state_q == ST_CNT_HI) ||
                 (state_q == ST_CNT_LO) || (state_q == ST_D_HI) ||
                 (state_q == ST_D_LO) || (state_q == ST_CSUM);
    wr_ok      = byte_state && !bus.utx_buffer_full && !abort;
    start_ok   = (state_q == ST_IDLE) && start && !abort;

    bus.utx_buffer_write = wr_ok;
    bus.data_in          = data_q;
    bus.mem_addr         = addr_q;
    bus.mem_rd_en        = (state_q == ST_FETCH);
    busy                 = (state_q != ST_IDLE);
    done                 = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_tx
// Bench for uart_frame_tx: sample memory and FIFO models around the DUT,
// directed frames from the test plan plus randomized frames with random
// FIFO back-pressure, all compared against a frame/schedule model.
// ---------------------------------------------------------------------------
module tb_uart_frame_tx;
  import la_pkg::*;

  localparam int ADDR_W    = 10;
  localparam int MEM_DEPTH = 1 << ADDR_W;
  localparam int MAX_CYC   = 600;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [15:0]       num_samples;
  logic              busy;
  logic              done;
  logic              full_drv;
  logic [15:0]       rd_data_q = 16'h0000;
  logic [15:0]       mem [MEM_DEPTH];

  int total_cnt = 0;
  int bad_cnt   = 0;

  // Observations from the most recent frame.
  logic [7:0]        byte_q[$];
  int                wcyc_q[$];
  logic [ADDR_W-1:0] raddr_q[$];
  int                rcyc_q[$];
  int                done_q[$];
  int                last_done_cyc;
  bit                full_hist [MAX_CYC];
  logic [7:0]        din_hist  [MAX_CYC];
  bit                wr_hist   [MAX_CYC];

  uart_frame_tx_if #(.ADDR_W(ADDR_W)) bus ();

  assign bus.utx_buffer_full = full_drv;
  assign bus.mem_rd_data     = rd_data_q;

  uart_frame_tx #(.ADDR_W(ADDR_W), .SOF(8'hA5)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .base_addr   (base_addr),
    .num_samples (num_samples),
    .busy        (busy),
    .done        (done),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Synchronous sample memory: data valid the cycle after the read enable.
  always @(posedge clk) begin
    if (bus.mem_rd_en) rd_data_q <= mem[bus.mem_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
    checkOutput({tag, "_rd_en"}, 32'(bus.mem_rd_en), 0);
    checkOutput({tag, "_data_in"}, 32'(bus.data_in), 0);
    checkOutput({tag, "_write"}, 32'(bus.utx_buffer_write), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
  endtask

  // Runs one frame from its start cycle (cycle 0) and checks it.
  //   stall_mode 0: FIFO never full, 1: random full, 2: full in cycles 10..12
  //   stop_cyc >= 0: abort (or reset if use_reset) asserted in that cycle
  //   extra_start_cyc: cycle in which a stray start is pulsed while busy
  task automatic applyStimulus(input string name, input logic [ADDR_W-1:0] base,
                               input int n, input int stall_mode, input int stop_cyc,
                               input bit use_reset, input int extra_start_cyc);
    logic [15:0]       nn;
    logic [15:0]       smp;
    logic [7:0]        csum;
    logic [7:0]        exp_bytes[$];
    logic [ADDR_W-1:0] exp_addr[$];
    int                exp_wcyc[$];
    int                exp_rcyc[$];
    int                slots[$];
    int                exp_done;
    int                ai;
    int                c;
    int                bi;
    int                limit;
    int                last_c;
    int                n_w;
    int                n_r;

    // Expected frame content straight from the framing rules.
    nn = n[15:0];
    exp_bytes.push_back(8'hA5);
    exp_bytes.push_back(nn[15:8]);
    exp_bytes.push_back(nn[7:0]);
    csum = nn[15:8] ^ nn[7:0];
    for (int k = 0; k < n; k++) begin
      ai  = (int'(base) + k) % MEM_DEPTH;
      exp_addr.push_back(ai[ADDR_W-1:0]);
      smp = mem[ai];
      exp_bytes.push_back(smp[15:8]);
      exp_bytes.push_back(smp[7:0]);
      csum = csum ^ smp[15:8] ^ smp[7:0];
    end
    exp_bytes.push_back(csum);

    byte_q  = {};
    wcyc_q  = {};
    raddr_q = {};
    rcyc_q  = {};
    done_q  = {};
    foreach (full_hist[i]) begin
      full_hist[i] = 1'b0;
      din_hist[i]  = 8'h00;
      wr_hist[i]   = 1'b0;
    end

    @(posedge clk);
    #1;
    base_addr   = base;
    num_samples = nn;
    start       = 1'b1;
    full_drv    = 1'b0;
    last_c      = 0;

    for (int cy = 0; cy < MAX_CYC; cy++) begin
      if (cy > 0) begin
        @(posedge clk);
        #1;
        start = (cy == extra_start_cyc);
        abort = !use_reset && (cy == stop_cyc);
        reset = use_reset && (cy == stop_cyc);
        case (stall_mode)
          1:       full_drv = ($urandom_range(0, 2) == 0);
          2:       full_drv = (cy >= 10 && cy <= 12);
          default: full_drv = 1'b0;
        endcase
      end
      full_hist[cy] = full_drv;
      @(negedge clk);
      din_hist[cy] = bus.data_in;
      wr_hist[cy]  = bus.utx_buffer_write;
      if (bus.utx_buffer_write) begin
        byte_q.push_back(bus.data_in);
        wcyc_q.push_back(cy);
      end
      if (bus.mem_rd_en) begin
        raddr_q.push_back(bus.mem_addr);
        rcyc_q.push_back(cy);
      end
      if (done) done_q.push_back(cy);
      if (stop_cyc >= 0 && cy == stop_cyc + 1) begin
        if (use_reset) checkResetValues({name, "_rst"});
        else checkOutput({name, "_abort_busy"}, 32'(busy), 0);
      end
      last_c = cy;
      if (cy > 0 && !busy) break;
    end
    checkOutput({name, "_end_busy"}, 32'(busy), 0);
    start    = 1'b0;
    abort    = 1'b0;
    reset    = 1'b0;
    full_drv = 1'b0;

    // Expected schedule: each byte slot waits out full cycles, each sample
    // costs a fetch and a wait cycle before its two bytes.
    slots = '{1, 1, 1};
    for (int k = 0; k < n; k++) begin
      slots.push_back(2);
      slots.push_back(3);
      slots.push_back(1);
      slots.push_back(1);
    end
    slots.push_back(1);

    limit = (stop_cyc >= 0) ? stop_cyc : MAX_CYC;
    c  = 1;
    bi = 0;
    foreach (slots[s]) begin
      if (slots[s] == 1) begin
        while (c < MAX_CYC - 1 && full_hist[c]) begin
          if (c < limit && c <= last_c) begin
            checkOutput($sformatf("%s_stall_din_c%0d", name, c), 32'(din_hist[c]), 32'(exp_bytes[bi]));
            checkOutput($sformatf("%s_stall_wr_c%0d", name, c), 32'(wr_hist[c]), 0);
          end
          c++;
        end
        exp_wcyc.push_back(c);
        bi++;
      end else if (slots[s] == 2) begin
        exp_rcyc.push_back(c);
      end
      c++;
    end
    exp_done = c;

    n_w = 0;
    foreach (exp_wcyc[i]) if (exp_wcyc[i] < limit) n_w++;
    n_r = 0;
    foreach (exp_rcyc[i]) if (exp_rcyc[i] < limit) n_r++;

    if (stop_cyc < 0) checkOutput({name, "_flen"}, exp_bytes.size(), 32'(frame_len(nn)));
    checkOutput({name, "_nbytes"}, byte_q.size(), n_w);
    for (int i = 0; i < n_w && i < byte_q.size(); i++) begin
      checkOutput($sformatf("%s_byte%0d", name, i), 32'(byte_q[i]), 32'(exp_bytes[i]));
      checkOutput($sformatf("%s_wcyc%0d", name, i), wcyc_q[i], exp_wcyc[i]);
    end
    checkOutput({name, "_nreads"}, raddr_q.size(), n_r);
    for (int i = 0; i < n_r && i < raddr_q.size(); i++) begin
      checkOutput($sformatf("%s_raddr%0d", name, i), 32'(raddr_q[i]), 32'(exp_addr[i]));
      checkOutput($sformatf("%s_rcyc%0d", name, i), rcyc_q[i], exp_rcyc[i]);
    end
    if (stop_cyc < 0) begin
      checkOutput({name, "_ndone"}, done_q.size(), 1);
      if (done_q.size() > 0) checkOutput({name, "_done_cyc"}, done_q[0], exp_done);
    end else begin
      checkOutput({name, "_ndone"}, done_q.size(), 0);
    end
    last_done_cyc = (done_q.size() > 0) ? done_q[0] : -1;
  endtask

  initial begin
    logic [ADDR_W-1:0] rb;

    reset       = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    full_drv    = 1'b0;
    base_addr   = '0;
    num_samples = '0;
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = 16'($urandom);
    mem[0]     = 16'h1234;
    mem[1]     = 16'hABCD;
    mem[10'h3FF] = 16'h5A0F;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetValues("init");
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] directed: two-sample frame");
    applyStimulus("tp1", '0, 2, 0, -1, 1'b0, -1);
    checkOutput("tp1_csum_byte", 32'((byte_q.size() > 7) ? byte_q[7] : 8'h00), 32'h42);
    checkOutput("tp1_done_abs", last_done_cyc, 13);

    $display("[TB] directed: empty frame");
    applyStimulus("tp2", '0, 0, 0, -1, 1'b0, -1);
    checkOutput("tp2_done_abs", last_done_cyc, 5);

    $display("[TB] directed: three-cycle stall on sample 1 high byte");
    applyStimulus("tp3", '0, 2, 2, -1, 1'b0, -1);
    checkOutput("tp3_done_abs", last_done_cyc, 16);

    $display("[TB] directed: address wrap");
    applyStimulus("tp4", 10'h3FF, 2, 0, -1, 1'b0, -1);
    checkOutput("tp4_a0", 32'((raddr_q.size() > 0) ? raddr_q[0] : '0), 32'h3FF);
    checkOutput("tp4_a1", 32'((raddr_q.size() > 1) ? raddr_q[1] : 10'h155), 32'h000);

    $display("[TB] directed: abort after 0x12 byte");
    applyStimulus("tp5", '0, 2, 0, 7, 1'b0, -1);
    checkOutput("tp5_no_done", last_done_cyc, 32'hFFFF_FFFF);
    applyStimulus("tp5_clean", 10'd5, 3, 0, -1, 1'b0, -1);

    $display("[TB] directed: start while busy, reset mid-frame");
    applyStimulus("tp6_start", '0, 2, 0, -1, 1'b0, 6);
    checkOutput("tp6_done_abs", last_done_cyc, 13);
    applyStimulus("tp6_reset", '0, 2, 0, 5, 1'b1, -1);
    applyStimulus("tp6_clean", '0, 2, 0, -1, 1'b0, -1);

    $display("[TB] randomized frames with back-pressure");
    for (int f = 0; f < 12; f++) begin
      rb = ADDR_W'($urandom);
      applyStimulus($sformatf("rnd%0d", f), rb, $urandom_range(0, 12), 1, -1, 1'b0, -1);
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
